demux_1to3_stream: RTL
======================

// Module: demux_1to3_stream
// PURPOSE
//   Packet-level 1-to-3 stream demultiplexer; inverse of the 3-to-1 word mux in the routing fabric.
//   A command (destination sel + word count) steers the next cmd_len input words to one of three
//   consumers (e.g. weight buffer, pixel buffer, bias buffer). Each output has a one-entry register
//   stage with valid/ready. Full throughput when the selected consumer holds ready high.
// PARAMETERS
//   WORD_SIZE  16  data word width
//   LEN_WIDTH  10  width of packet word count (max packet 2**LEN_WIDTH-1 words)
// PORTS
//   clk          in   1          system clock, all state on rising edge
//   rst_n        in   1          asynchronous active-low reset
//   cmd_valid    in   1          command present
//   cmd_ready    out  1          command accepted when cmd_valid & cmd_ready
//   cmd_sel      in   2          destination: 00->out 0, 01->out 1, 10->out 2, 11 illegal
//   cmd_len      in   LEN_WIDTH  words in packet; 0 illegal
//   in_data      in   WORD_SIZE  input word
//   in_valid     in   1          input word present
//   in_ready     out  1          word accepted when in_valid & in_ready
//   out_data_k   out  WORD_SIZE  k=0..2, registered output word
//   out_valid_k  out  1          k=0..2, output register holds a word
//   out_ready_k  in   1          k=0..2, consumer takes word when out_valid_k & out_ready_k
//   busy         out  1          1 while in ROUTE state
//   cmd_err      out  1          one-cycle pulse on rejected command
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, remaining=0, cur_sel=0, all out_valid_k=0,
//     all out_data_k=0, cmd_err=0; cmd_ready=1, in_ready=0, busy=0 once reset releases.
//   FSM IDLE: cmd_ready=1, in_ready=0. On command handshake:
//     - cmd_sel==11 or cmd_len==0 -> cmd_err=1 next cycle (one cycle), stay IDLE, nothing latched.
//     - else latch cur_sel=cmd_sel, remaining=cmd_len, go ROUTE.
//   FSM ROUTE: cmd_ready=0, busy=1. in_ready = ~out_valid_s | out_ready_s (s=cur_sel), combinational.
//     On input handshake: out_data_s<=in_data, out_valid_s<=1, remaining<=remaining-1.
//     Handshake with remaining==1 -> IDLE next cycle; new command acceptable that cycle.
//   Output register k: load has priority; if loaded and drained same cycle, out_valid_k stays 1
//     with new data. Drain without load -> out_valid_k<=0; out_data_k holds last value.
//   Latency: input accept at edge N -> out_valid_s=1 after edge N (visible cycle N+1).
//   Non-selected outputs never load; a word left from an earlier packet still drains independently.
//   No words dropped or duplicated; in_valid in IDLE ignored (in_ready=0), in_data never sampled.
//   remaining never underflows; cmd_len=2**LEN_WIDTH-1 supported.
//   Backpressure: out_ready_s low with out_valid_s=1 -> in_ready=0, state and data hold.
//   Reset mid-packet: packet abandoned, undrained output words discarded, state as above.
// TESTING
//   1. Reset, cmd sel=01 len=4, in_valid=1 words A1..A4, out_ready_1=1 -> out_1 emits A1..A4
//      on 4 consecutive cycles from cycle after first accept; busy low after 4th; out_0/out_2 valid=0.
//   2. cmd sel=11 len=3 -> cmd_err one-cycle pulse, cmd_ready stays 1, busy stays 0;
//      same for sel=00 len=0.
//   3. sel=10 len=3, out_ready_2 toggles 1,0,0,1,1 -> in_ready tracks ~out_valid_2|out_ready_2;
//      words emerge in order, none lost or duplicated.
//   4. sel=00 len=1 with out_ready_0=0 (word B held), then sel=01 len=2 streams on out_1 at
//      full rate while out_valid_0 stays 1 with B until out_ready_0 rises.
//   5. sel=00 len=8, assert rst_n=0 after 3 words -> all out_valid_k=0, busy=0 immediately;
//      after release new sel=01 len=1 routes correctly, remaining from old packet gone.
//   6. Random sel/len/ready traffic vs scoreboard: per-output order and counts match commands.

Source files
------------

// File: rtl/demux_1to3_stream.sv
// rtl/demux_1to3_stream.sv - packet-level 1-to-3 stream demultiplexer
// A command steers the next cmd_len input words into one of three one-entry output registers.
module demux_1to3_stream #(
   parameter int WORD_SIZE = 16,
   parameter int LEN_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_sel,
   input  logic [LEN_WIDTH-1:0] cmd_len,
   input  logic [WORD_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] out_data_0,
   output logic                 out_valid_0,
   input  logic                 out_ready_0,
   output logic [WORD_SIZE-1:0] out_data_1,
   output logic                 out_valid_1,
   input  logic                 out_ready_1,
   output logic [WORD_SIZE-1:0] out_data_2,
   output logic                 out_valid_2,
   input  logic                 out_ready_2,
   output logic                 busy,
   output logic                 cmd_err
);

   typedef enum logic {IDLE, ROUTE} state_t;

   state_t                 state, state_nx;
   logic [LEN_WIDTH-1:0]   remaining;
   logic [1:0]             cur_sel;
   logic [2:0]             valid_q;
   logic [WORD_SIZE-1:0]   data_q [0:2];
   logic [3:0]             valid_pad, ready_pad;
   logic [2:0]             ready_v, load, drain;
   logic                   cmd_hs, cmd_bad, in_hs;

   assign ready_v   = {out_ready_2, out_ready_1, out_ready_0};
   // Padded to four entries so cur_sel can index directly; entry 3 is never selected.
   assign valid_pad = {1'b0, valid_q};
   assign ready_pad = {1'b0, ready_v};
   assign cmd_bad   = (cmd_sel == 2'b11) || (cmd_len == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b0;
      cmd_hs    = 1'b0;
      in_hs     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            cmd_hs    = cmd_valid;
            if (cmd_hs && !cmd_bad) begin
               state_nx = ROUTE;
            end
         end
         ROUTE: begin
            busy     = 1'b1;
            in_ready = ~valid_pad[cur_sel] | ready_pad[cur_sel];
            in_hs    = in_valid & in_ready;
            if (in_hs && remaining == LEN_WIDTH'(1)) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         cur_sel   <= 2'b00;
         cmd_err   <= 1'b0;
      end else begin
         cmd_err <= cmd_hs & cmd_bad;
         if (cmd_hs && !cmd_bad) begin
            remaining <= cmd_len;
            cur_sel   <= cmd_sel;
         end else if (in_hs) begin
            remaining <= remaining - LEN_WIDTH'(1);
         end
      end
   end

   // Load wins over drain so a simultaneous load/drain keeps the register full.
   assign load  = in_hs ? (3'b001 << cur_sel) : 3'b000;
   assign drain = valid_q & ready_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (load[k]) begin
               data_q[k]  <= in_data;
               valid_q[k] <= 1'b1;
            end else if (drain[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign out_data_0  = data_q[0];
   assign out_data_1  = data_q[1];
   assign out_data_2  = data_q[2];
   assign out_valid_0 = valid_q[0];
   assign out_valid_1 = valid_q[1];
   assign out_valid_2 = valid_q[2];

endmodule
